fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the IF/ID pipeline register. Owns the fetch PC and issues in-order word reads on the instruction bus with a req/gnt/rvalid handshake. Buffers returned words with their addresses in a small FIFO and presents the head as `inst_o`/`inst_addr_o` for IF/ID to capture. Redirects on `jump_enable_i`, discards in-flight stale responses, and holds its output while the pipeline is stalled.

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit_sync_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared instruction-bus types and constants for the fetch
//               stage: NOP encoding, the idle instruction address, the bus
//               word types, and the {address, instruction} FIFO entry.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  typedef logic [31:0] inst_bus_t;
  typedef logic [31:0] inst_addr_bus_t;

  // addi x0, x0, 0
  localparam inst_bus_t      INST_NOP       = 32'h0000_0013;
  localparam inst_addr_bus_t ZERO_INST_ADDR = 32'h0000_0000;

  typedef struct packed {
    inst_addr_bus_t addr;
    inst_bus_t      inst;
  } fetch_entry_t;

  // Word-align an address by clearing the byte-offset bits.
  function automatic inst_addr_bus_t word_align(input inst_addr_bus_t a);
    return a & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction bus with req/gnt/rvalid handshake.
//               master : fetch side (drives req/addr, receives gnt/rvalid/rdata)
//               slave  : memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic           req;
  inst_addr_bus_t addr;
  logic           gnt;
  logic           rvalid;
  inst_bus_t      rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface
`default_nettype wire

// File: rtl/fetch_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_sync_fifo
// Description : Single-clock FIFO with push/pop/clear, occupancy count and
//               empty/full flags. DEPTH must be a power of two.
//               Ports: clk_i, rst_i (async, active-high), clear_i, push_i,
//               data_i, pop_i, data_o (head, combinational), count_o,
//               empty_o, full_o.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(DEPTH));
  assign data_o  = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted only when a pop frees a slot.
  assign w_push = push_i && (!full_o || pop_i);
  assign w_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !clear_i) r_mem[r_wr_ptr] <= data_i;
  end

  assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the fetch PC, issues in-order
//               word reads on the instruction bus, pairs responses with their
//               addresses and buffers them for the IF/ID register. Handles
//               redirects (flush + discard of in-flight responses) and stalls.
//               Ports: clk_i, rst_i (async, active-high), jump_enable_i,
//               jump_addr_i, hold_enable_i, ibus (master), inst_o,
//               inst_addr_o, inst_valid_o.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter inst_addr_bus_t RESET_ADDR = 32'h0000_0000,
  parameter int             DEPTH      = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           jump_enable_i,
  input  inst_addr_bus_t jump_addr_i,
  input  logic           hold_enable_i,
  fetch_unit_if.master   ibus,
  output inst_bus_t      inst_o,
  output inst_addr_bus_t inst_addr_o,
  output logic           inst_valid_o
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  inst_addr_bus_t r_req_pc;
  inst_addr_bus_t r_pend_addr;
  logic           r_pending;
  logic           r_pend_stale;   // pending request was raised before a jump
  logic [CW-1:0]  r_discard;

  logic [CW-1:0]  w_outstanding;
  logic [CW-1:0]  w_fifo_count;
  logic           w_fifo_empty;
  logic           w_fifo_full;
  logic           w_aq_empty;
  logic           w_aq_full;
  fetch_entry_t   w_head;
  fetch_entry_t   w_push_entry;
  inst_addr_bus_t w_rsp_addr;
  inst_addr_bus_t w_jump_target;
  inst_addr_bus_t w_issue_addr;
  logic [CW:0]    w_occupancy;
  logic           w_can_issue;
  logic           w_req;
  logic           w_fire;
  logic           w_valid;
  logic           w_pop;
  logic           w_drop;
  logic           w_push;
  logic [CW-1:0]  w_discard_next;
  logic           w_unused;

  assign w_jump_target = word_align(jump_addr_i);

  // ---------------------------------------------------------------- output
  assign w_valid = !w_fifo_empty && !jump_enable_i;
  assign w_pop   = w_valid && !hold_enable_i;

  assign inst_valid_o = w_valid;
  assign inst_o       = w_valid ? w_head.inst : INST_NOP;
  assign inst_addr_o  = w_valid ? w_head.addr : ZERO_INST_ADDR;

  // --------------------------------------------------------------- request
  // Outstanding requests plus buffered words never exceed DEPTH, so every
  // response that is kept always finds room in the FIFO.
  assign w_occupancy = {1'b0, w_outstanding} + {1'b0, w_fifo_count}
                     - {{CW{1'b0}}, w_pop};
  assign w_can_issue = w_occupancy < {1'b0, c_depth};

  // Held low during reset so the first request appears after release.
  assign w_req = !rst_i && (w_can_issue || r_pending);

  // A jump with nothing pending requests the new target in the same cycle.
  assign w_issue_addr = r_pending     ? r_pend_addr   :
                        jump_enable_i ? w_jump_target : r_req_pc;
  assign w_fire = w_req && ibus.gnt;

  assign ibus.req  = w_req;
  assign ibus.addr = w_issue_addr;

  // -------------------------------------------------------------- response
  assign w_drop       = jump_enable_i || (r_discard != '0);
  assign w_push       = ibus.rvalid && !w_drop;
  assign w_push_entry = '{addr: w_rsp_addr, inst: ibus.rdata};

  // On a jump every response still owed is stale, including one granted this
  // cycle if it carries a pre-jump (pending) address. Afterwards, a stale
  // pending request adds itself to the discard count when finally granted.
  always_comb begin
    w_discard_next = r_discard;
    if (jump_enable_i) begin
      w_discard_next = w_outstanding - CW'(ibus.rvalid) + CW'(w_fire && r_pending);
    end else begin
      if (ibus.rvalid && (r_discard != '0)) w_discard_next = w_discard_next - CW'(1);
      if (w_fire && r_pend_stale)           w_discard_next = w_discard_next + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req_pc     <= RESET_ADDR;
      r_pend_addr  <= RESET_ADDR;
      r_pending    <= 1'b0;
      r_pend_stale <= 1'b0;
      r_discard    <= '0;
    end else begin
      r_discard <= w_discard_next;

      if (jump_enable_i) begin
        r_req_pc <= (w_fire && !r_pending) ? w_jump_target + 32'd4 : w_jump_target;
      end else if (w_fire && !r_pend_stale) begin
        r_req_pc <= r_req_pc + 32'd4;
      end

      if (w_req && !ibus.gnt) begin
        r_pending    <= 1'b1;
        r_pend_addr  <= w_issue_addr;
        r_pend_stale <= r_pending && (r_pend_stale || jump_enable_i);
      end else begin
        r_pending    <= 1'b0;
        r_pend_stale <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------ buffering
  fetch_unit_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (jump_enable_i),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_fifo_count),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full)
  );

  // Address queue: its occupancy is the number of outstanding requests.
  // Never flushed, so discarded responses still pop their address.
  fetch_unit_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_addr_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (1'b0),
    .push_i  (w_fire),
    .data_i  (w_issue_addr),
    .pop_i   (ibus.rvalid),
    .data_o  (w_rsp_addr),
    .count_o (w_outstanding),
    .empty_o (w_aq_empty),
    .full_o  (w_aq_full)
  );

  // Flags implied by the occupancy bound; kept for observability only.
  assign w_unused = ^{w_fifo_full, w_aq_full, w_aq_empty};

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. The bus model
//               returns ~address as data, in order, one response per cycle
//               unless responses are held back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam inst_addr_bus_t RA    = 32'hFFFF_FFF8;
  localparam int             DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           jump_enable_i;
  inst_addr_bus_t jump_addr_i;
  logic           hold_enable_i;
  inst_bus_t      inst_o;
  inst_addr_bus_t inst_addr_o;
  logic           inst_valid_o;

  fetch_unit_if ibus();

  fetch_unit #(.RESET_ADDR(RA), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .jump_enable_i (jump_enable_i),
    .jump_addr_i   (jump_addr_i),
    .hold_enable_i (hold_enable_i),
    .ibus          (ibus),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk = ~clk;

  int             n_tests = 0;
  int             n_fail  = 0;
  inst_addr_bus_t rsp_q[$];
  bit             rsp_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Record this cycle's grant, advance one clock, then drive the response.
  task automatic next();
    if (ibus.req && ibus.gnt) rsp_q.push_back(ibus.addr);
    @(posedge clk);
    #1;
    if (!rsp_hold && rsp_q.size() > 0) begin
      ibus.rvalid = 1'b1;
      ibus.rdata  = ~rsp_q.pop_front();
    end else begin
      ibus.rvalid = 1'b0;
      ibus.rdata  = 32'h0;
    end
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset release.
  task automatic do_reset();
    rst_i         = 1'b1;
    jump_enable_i = 1'b0;
    jump_addr_i   = 32'h0;
    hold_enable_i = 1'b0;
    ibus.gnt      = 1'b1;
    ibus.rvalid   = 1'b0;
    ibus.rdata    = 32'h0;
    rsp_hold      = 1'b0;
    rsp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; jump_enable_i = 1'b0; jump_addr_i = 32'h0; hold_enable_i = 1'b0;
    ibus.gnt = 1'b1; ibus.rvalid = 1'b0; ibus.rdata = 32'h0; rsp_hold = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("rst_req",       {31'd0, ibus.req},     32'd0);
    check("rst_ibus_addr", ibus.addr,             RA);
    check("rst_inst",      inst_o,                INST_NOP);
    check("rst_inst_addr", inst_addr_o,           32'h0);
    check("rst_valid",     {31'd0, inst_valid_o}, 32'd0);

    // Streaming from RESET_ADDR with wrap past 32'hFFFF_FFFC.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      check("t1_req",  {31'd0, ibus.req}, 32'd1);
      check("t1_ibus_addr", ibus.addr, RA + 32'(4 * c));
      if (c >= 2) begin
        check("t1_valid", {31'd0, inst_valid_o}, 32'd1);
        check("t1_addr",  inst_addr_o, RA + 32'(4 * (c - 2)));
        check("t1_inst",  inst_o, ~(RA + 32'(4 * (c - 2))));
      end else begin
        check("t1_valid", {31'd0, inst_valid_o}, 32'd0);
      end
      next();
    end

    // Asynchronous reset mid-stream: outputs fall back with no clock edge.
    #3 rst_i = 1'b1;
    #1;
    check("t6_req",       {31'd0, ibus.req},     32'd0);
    check("t6_valid",     {31'd0, inst_valid_o}, 32'd0);
    check("t6_inst",      inst_o,                INST_NOP);
    check("t6_inst_addr", inst_addr_o,           32'h0);
    check("t6_ibus_addr", ibus.addr,             RA);

    // Grant withheld for 3 cycles: request stays up with a stable address.
    do_reset();
    ibus.gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t2_req",  {31'd0, ibus.req}, 32'd1);
      check("t2_addr", ibus.addr, RA);
      next();
    end
    ibus.gnt = 1'b1;
    #1; check("t2_grant_addr", ibus.addr, RA);       next();
    #1; check("t2_next_addr",  ibus.addr, RA + 32'd4); next();
    #1; check("t2_valid", {31'd0, inst_valid_o}, 32'd1);
        check("t2_head0", inst_addr_o, RA);            next();
    #1; check("t2_head1", inst_addr_o, RA + 32'd4);    next();

    // Hold for cycles 3..7: head frozen, requests stop at DEPTH buffered.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      hold_enable_i = (c >= 3 && c <= 7);
      #1;
      check("t3_req", {31'd0, ibus.req}, (c >= 5 && c <= 7) ? 32'd0 : 32'd1);
      if (c >= 2)
        check("t3_head", inst_addr_o,
              (c == 2) ? RA : (c <= 8) ? RA + 32'd4 : RA + 32'(4 * (c - 7)));
      if (c == 8) check("t3_resume_addr", ibus.addr, RA + 32'd20);
      next();
    end
    hold_enable_i = 1'b0;

    // Jump with two responses outstanding: both dropped, target word-aligned.
    do_reset();
    rsp_hold = 1'b1;
    #1; next();
    #1; next();
    jump_enable_i = 1'b1; jump_addr_i = 32'h0000_0102; hold_enable_i = 1'b1;
    rsp_hold = 1'b0;
    #1;
    check("t4_bubble_valid", {31'd0, inst_valid_o}, 32'd0);
    check("t4_bubble_inst",  inst_o,      INST_NOP);
    check("t4_bubble_addr",  inst_addr_o, 32'h0);
    check("t4_jump_req",     {31'd0, ibus.req}, 32'd1);
    check("t4_jump_ibus",    ibus.addr,   32'h0000_0100);
    next();
    jump_enable_i = 1'b0; hold_enable_i = 1'b0;
    for (int c = 3; c < 6; c++) begin
      #1; check("t4_drop_valid", {31'd0, inst_valid_o}, 32'd0); next();
    end
    #1; check("t4_valid", {31'd0, inst_valid_o}, 32'd1);
        check("t4_addr",  inst_addr_o, 32'h0000_0100);
        check("t4_inst",  inst_o, ~32'h0000_0100);  next();
    #1; check("t4_addr_next", inst_addr_o, 32'h0000_0104); next();

    // Jump while a request is pending: old address granted, its data dropped.
    do_reset();
    ibus.gnt = 1'b0;
    #1; check("t5_req", {31'd0, ibus.req}, 32'd1); next();
    jump_enable_i = 1'b1; jump_addr_i = 32'h0000_0200;
    #1; check("t5_pend_req",  {31'd0, ibus.req}, 32'd1);
        check("t5_pend_addr", ibus.addr, RA);
        check("t5_bubble",    {31'd0, inst_valid_o}, 32'd0); next();
    jump_enable_i = 1'b0; ibus.gnt = 1'b1;
    #1; check("t5_old_grant", ibus.addr, RA); next();
    #1; check("t5_target_req", ibus.addr, 32'h0000_0200);
        check("t5_drop_valid", {31'd0, inst_valid_o}, 32'd0); next();
    #1; check("t5_wait_valid", {31'd0, inst_valid_o}, 32'd0); next();
    #1; check("t5_valid", {31'd0, inst_valid_o}, 32'd1);
        check("t5_addr",  inst_addr_o, 32'h0000_0200); next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
